// File: rtl/aes_key_expand.sv
// AES-128 byte substitution: combinational S-box lookup for one byte.
// Latency: 0 cycles, pure lookup.
// Backpressure: none.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[a];

endmodule

// AES-128 key schedule: emits round keys 0..NROUNDS on a valid/ready stream.
// Latency: first key valid 1 cycle after start; one key per cycle while ready is high.
// Backpressure: rk_ready low holds roundkey/round/rcon/rk_valid; start ignored while expanding.
module aes_key_expand #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state, state_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic [127:0] roundkey_nxt;
  logic [3:0]   round_nxt;
  logic         rk_valid_nxt;
  logic         busy_nxt;
  logic         done_nxt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;
  logic [7:0]   rcon_xtime;

  assign w0 = roundkey[127:96];
  assign w1 = roundkey[95:64];
  assign w2 = roundkey[63:32];
  assign w3 = roundkey[31:0];

  // RotWord: rotate left by one byte.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sbox u_sbox0 (.a(rot_w3[31:24]), .y(sub_w3[31:24]));
  sbox u_sbox1 (.a(rot_w3[23:16]), .y(sub_w3[23:16]));
  sbox u_sbox2 (.a(rot_w3[15:8]),  .y(sub_w3[15:8]));
  sbox u_sbox3 (.a(rot_w3[7:0]),   .y(sub_w3[7:0]));

  // Round constant only touches the most significant byte of the word.
  assign t   = sub_w3 ^ {rcon, 24'h000000};
  assign nw0 = w0 ^ t;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  // GF(2^8) doubling for the next round constant.
  assign rcon_xtime = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);

  // Next-state and next-output decode for the two-state controller.
  always_comb begin
    state_nxt    = state;
    roundkey_nxt = roundkey;
    round_nxt    = round;
    rcon_nxt     = rcon;
    rk_valid_nxt = rk_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        rk_valid_nxt = 1'b0;
        if (start) begin
          roundkey_nxt = key;
          round_nxt    = 4'd0;
          rcon_nxt     = 8'h01;
          rk_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = EXPAND;
        end
      end
      EXPAND: begin
        if (rk_valid && rk_ready) begin
          if (round == 4'(NROUNDS)) begin
            // Last key taken: keep roundkey/round, drop valid, pulse done.
            rk_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
          end else begin
            roundkey_nxt = next_key;
            round_nxt    = round + 4'd1;
            rcon_nxt     = rcon_xtime;
            rk_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        rk_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any expansion in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      roundkey <= '0;
      round    <= 4'd0;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      roundkey <= roundkey_nxt;
      round    <= round_nxt;
      rcon     <= rcon_nxt;
      rk_valid <= rk_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for the AES-128 key schedule engine.
// Drives and samples on the falling edge, well away from the active rising edge.
// Consumer handshakes are recorded and compared with FIPS-197 round keys.
module tb_aes_key_expand;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] roundkey;
  logic [3:0]   round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  logic [127:0] a1_exp [0:10];
  logic [127:0] got_key [0:15];
  logic [3:0]   got_rnd [0:15];
  int           n_got;
  int           first_cyc;
  int           last_cyc;
  int           done_cyc;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_ALT  = 128'hffeeddccbbaa99887766554433221100;

  aes_key_expand #(.NROUNDS(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .key      (key),
    .roundkey (roundkey),
    .round    (round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one expansion as consumer. Cycle 1 is the first falling edge after
  // the caller drove start. Optionally pulses start with another key at
  // round 4, and optionally restarts with restart_key in the done cycle.
  task automatic collect(input bit rnd, input bit inj_start, input bit restart,
                         input logic [127:0] restart_key);
    bit           prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_rnd;
    bit           finished;
    prev_stall = 1'b0;
    prev_key   = '0;
    prev_rnd   = '0;
    finished   = 1'b0;
    n_got      = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    done_cyc   = -1;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (prev_stall) begin
        check("stall_key", roundkey, prev_key);
        check("stall_round", {124'h0, round}, {124'h0, prev_rnd});
        check("stall_valid", {127'h0, rk_valid}, 128'h1);
      end
      if (done) begin
        done_cyc = cyc;
        check("done_busy_low", {127'h0, busy}, 128'h0);
        check("done_valid_low", {127'h0, rk_valid}, 128'h0);
        check("done_after_last", done_cyc, last_cyc + 1);
        if (restart) begin
          start = 1'b1;
          key   = restart_key;
        end
        rk_ready = 1'b0;
        finished = 1'b1;
      end else begin
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inj_start && rk_valid && round == 4'd4) begin
          start = 1'b1;
          key   = KEY_ALT;
        end
        if (rk_valid && rk_ready) begin
          if (n_got < 16) begin
            got_key[n_got] = roundkey;
            got_rnd[n_got] = round;
          end
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          n_got++;
        end
        prev_stall = rk_valid && !rk_ready;
        prev_key   = roundkey;
        prev_rnd   = round;
      end
    end
    if (!finished) check("timeout_no_done", 128'h0, 128'h1);
  endtask

  task automatic check_a1(input string tag);
    check({tag, "_count"}, n_got, 11);
    for (int i = 0; i < 11 && i < n_got; i++) begin
      check($sformatf("%s_key%0d", tag, i), got_key[i], a1_exp[i]);
      check($sformatf("%s_rnd%0d", tag, i), {124'h0, got_rnd[i]}, 128'(i));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    key      = '0;
    rk_ready = 1'b0;

    a1_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Step 1: reset state.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {127'h0, rk_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_round", {124'h0, round}, 128'h0);
    check("rst_roundkey", roundkey, 128'h0);

    // Step 2: idle without start stays quiet.
    @(negedge clk);
    check("idle_valid", {127'h0, rk_valid}, 128'h0);

    // Step 3: FIPS-197 A.1 with rk_ready held high.
    start = 1'b1;
    key   = KEY_A1;
    collect(1'b0, 1'b0, 1'b0, '0);
    check_a1("a1");
    check("a1_first_latency", first_cyc, 1);
    check("a1_consecutive", last_cyc - first_cyc, 10);
    @(negedge clk);
    check("a1_done_one_cycle", {127'h0, done}, 128'h0);
    check("a1_hold_round", {124'h0, round}, 128'd10);
    check("a1_hold_key", roundkey, a1_exp[10]);

    // Step 4: all-zero key.
    start = 1'b1;
    key   = KEY_ZERO;
    collect(1'b0, 1'b0, 1'b0, '0);
    check("zero_count", n_got, 11);
    check("zero_key0", got_key[0], 128'h0);
    check("zero_key1", got_key[1], 128'h62636363626363636263636362636363);
    check("zero_key2", got_key[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    check("zero_key10", got_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Step 5: random backpressure on the A.1 key.
    @(negedge clk);
    start = 1'b1;
    key   = KEY_A1;
    collect(1'b1, 1'b0, 1'b0, '0);
    check_a1("bp");

    // Step 6: start with another key at round 4 is ignored.
    @(negedge clk);
    start = 1'b1;
    key   = KEY_A1;
    collect(1'b0, 1'b1, 1'b0, '0);
    check_a1("ign");

    // Step 7: asynchronous reset at round 6, then zero key.
    @(negedge clk);
    start = 1'b1;
    key   = KEY_A1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !(rk_valid && round == 4'd6); i++) @(negedge clk);
    check("pre_rst_round6", {124'h0, round}, 128'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {127'h0, rk_valid}, 128'h0);
    check("arst_busy", {127'h0, busy}, 128'h0);
    check("arst_done", {127'h0, done}, 128'h0);
    check("arst_round", {124'h0, round}, 128'h0);
    check("arst_roundkey", roundkey, 128'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {127'h0, rk_valid}, 128'h0);
    start = 1'b1;
    key   = KEY_ZERO;
    collect(1'b0, 1'b0, 1'b0, '0);
    check("rz_count", n_got, 11);
    check("rz_key1", got_key[1], 128'h62636363626363636263636362636363);
    check("rz_key10", got_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Step 8: restart in the done-pulse cycle.
    @(negedge clk);
    start = 1'b1;
    key   = KEY_ZERO;
    collect(1'b0, 1'b0, 1'b1, KEY_A1);
    check("bb_first_count", n_got, 11);
    collect(1'b0, 1'b0, 1'b0, '0);
    check("bb_latency", first_cyc, 1);
    check_a1("bb");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
AES-128 key schedule engine (FIPS-197 Section 5.2). It takes a 128-bit cipher key and produces the 11 round keys (rounds 0..10) one per handshake on a valid/ready stream. It sits downstream of the byte-substitution ROM: it instantiates 4 sBox instances to implement SubWord. It feeds the cipher round datapath, which consumes one round key per round.

Parameters:
NROUNDS, 10, index of the last round key emitted; legal range 1..10; 10 for AES-128.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request expansion of key; sampled only in IDLE
key  input  128  cipher key; key[127:120] = byte 0; sampled with start
roundkey  output  128  current round key; w0 = [127:96], w3 = [31:0]
round  output  4  index of roundkey, 0..NROUNDS
rk_valid  output  1  roundkey/round valid
rk_ready  input  1  consumer accepts roundkey when rk_valid and rk_ready are both high
busy  output  1  high from the cycle after start is accepted until the last key is accepted
done  output  1  one-cycle pulse after round NROUNDS is accepted

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- Reset, asynchronous when reset_n=0: state=IDLE, roundkey=0, round=0, rk_valid=0, busy=0, done=0, rcon=8'h01. Reset mid-expansion aborts immediately. No key is emitted until a new start.
- States: IDLE, EXPAND.
- IDLE + start=1: on the next edge, roundkey<=key, round<=0, rcon<=8'h01, rk_valid<=1, busy<=1, state<=EXPAND. Latency from start to the first valid key is 1 cycle.
- IDLE + start=0: hold. rk_valid=0.
- EXPAND, handshake (rk_valid & rk_ready), round<NROUNDS: on the next edge, roundkey<=next_key, round<=round+1, rcon<=xtime(rcon), rk_valid stays 1. With rk_ready held high, one key is emitted per cycle.
- EXPAND, handshake, round==NROUNDS: on the next edge, rk_valid<=0, busy<=0, done<=1 for 1 cycle, state<=IDLE. roundkey and round hold their last values.
- EXPAND, rk_ready=0: roundkey, round, rcon and rk_valid are held stable (no skipped or duplicated keys).
- start is ignored in EXPAND and does not alter key or progress.
- start in the done-pulse cycle (state already IDLE) is accepted. The first key of the new expansion is valid on the next cycle, giving back-to-back expansions with 1 idle cycle.
- next_key, combinational from the registered roundkey and rcon:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - RotWord(w3) = {w3[23:0], w3[31:24]}
  - SubWord applies the 4 sBox instances bytewise
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
- rcon update: xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00). The sequence is 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
- All outputs are registered except as noted. There is no combinational path from rk_ready or start to any output.

Test Plan:
- FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1 constant.
  - Required: rk_valid for 11 consecutive cycles starting 1 cycle after start.
  - round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 2 = f2c295f27a96b9435935807a7359f67f; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses 1 cycle after the round-10 handshake; busy falls the same cycle.
- All-zero key -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: A.1 key with rk_ready randomly toggled (~50%) -> same 11 keys in order, no gaps or repeats. roundkey/round are stable whenever rk_valid=1 and rk_ready=0.
- start pulsed with a different key at round 4 -> ignored; round 5..10 values still match the A.1 vector.
- reset_n asserted asynchronously at round 6 -> rk_valid, busy, done and round drop to 0 without waiting for a clock edge. A subsequent start with the zero key produces the correct zero-key sequence.
- start asserted in the done-pulse cycle with the A.1 key -> round 0 valid on the next cycle, and the full A.1 sequence repeats correctly.
